ram_line_fifo_ntap: RTL

- Parametrised line-buffer FIFO whose elements are whole video lines, each held in its own RAM.
- One line is filled while READ_ROWS consecutive older lines are read in parallel, two horizontally adjacent pixels per row, giving a READ_ROWS x 2 neighbourhood.
- Sits between the input pixel writer and the scaler interpolation stage.
- Adds variable-stride read advance, full/empty flags, guarded writes, per-row valid and sticky overflow/underflow error flags.

---
 rtl/ram_line_fifo_ntap.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ram_line_fifo_ntap.sv
// Line-buffer FIFO: one RAM per video line, one line filled while READ_ROWS
// older lines are read two adjacent pixels at a time for the scaler.
module ram_line_fifo_ntap #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUFFER_SIZE   = 4,
  parameter int READ_ROWS     = 2,
  parameter int ADV_WIDTH     = $clog2(READ_ROWS + 1),
  parameter int FILL_WIDTH    = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             writeData,
  input  logic [ADDRESS_WIDTH-1:0]          writeAddress,
  input  logic                              writeEnable,
  input  logic                              advanceWrite,
  input  logic [ADV_WIDTH-1:0]              advanceRead,
  input  logic                              forceRead,
  input  logic [ADDRESS_WIDTH-1:0]          readAddress,
  output logic [READ_ROWS*2*DATA_WIDTH-1:0] readData,
  output logic [READ_ROWS-1:0]              rowValid,
  output logic [FILL_WIDTH-1:0]             fillCount,
  output logic                              full,
  output logic                              empty,
  output logic                              overflow,
  output logic                              underflow,
  input  logic                              clearErrors
);

  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]             r_mem [BUFFER_SIZE][DEPTH];
  logic [IDX_W-1:0]                  r_writeIdx;
  logic [IDX_W-1:0]                  r_readIdx;
  logic [FILL_WIDTH-1:0]             r_fill;
  logic                              r_full;
  logic                              r_empty;
  logic                              r_overflow;
  logic                              r_underflow;
  logic [READ_ROWS*2*DATA_WIDTH-1:0] r_readData;
  logic [READ_ROWS-1:0]              r_rowValid;

  logic                              w_rdOk;
  logic                              w_wrOk;
  logic                              w_wrEn;
  int                                w_nEff;
  int                                w_fillNext;
  logic [ADDRESS_WIDTH-1:0]          w_addrNext;
  logic [IDX_W-1:0]                  w_rowIdx [READ_ROWS];

  // Modular add for ring indices; inc never exceeds BUFFER_SIZE, so one fold suffices.
  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int inc);
    int t;
    t = base + inc;
    if (t >= BUFFER_SIZE) t = t - BUFFER_SIZE;
    return IDX_W'(t);
  endfunction

  always_comb begin
    w_rdOk     = (int'(advanceRead) <= int'(r_fill)) && (int'(advanceRead) <= READ_ROWS);
    w_nEff     = w_rdOk ? int'(advanceRead) : 0;
    // Retiring lines in the same cycle frees room for the committing line.
    w_wrOk     = advanceWrite && ((int'(r_fill) - w_nEff) < BUFFER_SIZE);
    w_fillNext = int'(r_fill) + (w_wrOk ? 1 : 0) - w_nEff;
    w_wrEn     = writeEnable && !forceRead && !r_full;
    w_addrNext = readAddress + ADDRESS_WIDTH'(1);
    for (int r = 0; r < READ_ROWS; r++) begin
      w_rowIdx[r] = wrap_idx(int'(r_readIdx), r);
    end
  end

  // Control: ring indices, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_writeIdx  <= '0;
      r_readIdx   <= '0;
      r_fill      <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_readIdx <= wrap_idx(int'(r_readIdx), w_nEff);
      if (w_wrOk) r_writeIdx <= wrap_idx(int'(r_writeIdx), 1);
      r_fill  <= FILL_WIDTH'(w_fillNext);
      r_full  <= (w_fillNext == BUFFER_SIZE);
      r_empty <= (w_fillNext == 0);
      if (advanceWrite && !w_wrOk) r_overflow <= 1'b1;
      else if (clearErrors)        r_overflow <= 1'b0;
      if (!w_rdOk)                 r_underflow <= 1'b1;
      else if (clearErrors)        r_underflow <= 1'b0;
    end
  end

  // Line RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[r_writeIdx][writeAddress] <= writeData;
  end

  // Read stage: two synchronous ports per row, one cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_readData <= '0;
      r_rowValid <= '0;
    end else begin
      for (int r = 0; r < READ_ROWS; r++) begin
        r_readData[(2*r)*DATA_WIDTH +: DATA_WIDTH]   <= r_mem[w_rowIdx[r]][readAddress];
        r_readData[(2*r+1)*DATA_WIDTH +: DATA_WIDTH] <= r_mem[w_rowIdx[r]][w_addrNext];
        r_rowValid[r] <= (r < int'(r_fill));
      end
    end
  end

  assign readData  = r_readData;
  assign rowValid  = r_rowValid;
  assign fillCount = r_fill;
  assign full      = r_full;
  assign empty     = r_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
